// File: rtl/pipeline_bus_arbiter_pkg.sv
// Shared encodings for the pipeline memory-bus arbiter: FSM state codes,
// address-source select codes and the registered output bundle decode.
package pipeline_bus_arbiter_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_DMA   = 3'd3;
  localparam logic [2:0] S_TURN  = 3'd4;

  localparam logic [1:0] ADDR_NONE  = 2'd0;
  localparam logic [1:0] ADDR_PCRA  = 2'd1;
  localparam logic [1:0] ADDR_PIPE2 = 2'd2;
  localparam logic [1:0] ADDR_DMA   = 2'd3;

  typedef struct packed {
    logic       fetch_grant;
    logic       data_grant;
    logic       dma_grant;
    logic [1:0] addr_sel;
    logic       pipe_stall;
    logic       dma_active;
  } bus_out_t;

  // Output bundle for a given state; S_FETCH without a fetch request is the
  // parked condition (bus idle but Stages 0/1 not stalled).
  function automatic bus_out_t decode_outputs(input logic [2:0] state,
                                              input logic       fetch_req);
    bus_out_t o;
    o             = '0;
    o.addr_sel    = ADDR_NONE;
    o.pipe_stall  = 1'b1;
    case (state)
      S_FETCH: begin
        o.fetch_grant = fetch_req;
        o.addr_sel    = fetch_req ? ADDR_PCRA : ADDR_NONE;
        o.pipe_stall  = 1'b0;
      end
      S_DATA: begin
        o.data_grant  = 1'b1;
        o.addr_sel    = ADDR_PIPE2;
      end
      S_DMA: begin
        o.dma_grant   = 1'b1;
        o.addr_sel    = ADDR_DMA;
        o.dma_active  = 1'b1;
      end
      default: ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/pipeline_bus_arbiter.sv
// Arbiter for the shared 8-bit memory bus: Stage 2 data access, bounded DMA
// bursts with a minimum pipeline gap, and Stage 0 fetch. Outputs registered.
module pipeline_bus_arbiter
  import pipeline_bus_arbiter_pkg::*;
#(
  parameter int unsigned DMA_MAX_BURST = 16,
  parameter int unsigned DMA_GAP       = 2
) (
  input  logic       ClockIn,
  input  logic       ResetIn_n,
  input  logic       FetchReq,
  input  logic       DataReq,
  input  logic       DmaReq,
  output logic       FetchGrant,
  output logic       DataGrant,
  output logic       DmaGrant,
  output logic [1:0] AddrSel,
  output logic       PipeStall,
  output logic       DmaActive
);

  localparam int unsigned BW = $clog2(DMA_MAX_BURST + 1);
  localparam int unsigned GW = $clog2(DMA_GAP + 1);

  logic [2:0]    state, state_nxt;
  logic [BW-1:0] burst_cnt;
  logic [GW-1:0] gap_cnt, gap_nxt;
  logic          data_req;
  logic          dma_ok;
  logic          burst_last;
  bus_out_t      outs;

  // Unknown feedback from the pipeline at power-up must not claim the bus.
  assign data_req = (DataReq === 1'b1);

  assign burst_last = (burst_cnt == BW'(DMA_MAX_BURST - 1));

  // DMA eligibility looks at the post-edge gap value so exactly DMA_GAP
  // pipeline-owned cycles separate two bursts.
  always_comb begin
    gap_nxt = gap_cnt;
    if (state == S_TURN)
      gap_nxt = GW'(DMA_GAP);
    else if (state != S_DMA && gap_cnt != '0)
      gap_nxt = gap_cnt - 1'b1;
  end

  assign dma_ok = (gap_nxt == '0);

  always_comb begin
    state_nxt = S_FETCH;
    if (state == S_DMA) begin
      if (!DmaReq || burst_last)
        state_nxt = S_TURN;
      else
        state_nxt = S_DMA;
    end else if (data_req) begin
      state_nxt = S_DATA;
    end else if (DmaReq && dma_ok) begin
      state_nxt = S_DMA;
    end
  end

  always_ff @(posedge ClockIn or negedge ResetIn_n) begin
    if (!ResetIn_n) begin
      state     <= S_IDLE;
      outs      <= decode_outputs(S_IDLE, 1'b0);
      burst_cnt <= '0;
      gap_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      outs      <= decode_outputs(state_nxt, FetchReq);
      gap_cnt   <= gap_nxt;
      if (state == S_DMA && state_nxt == S_DMA)
        burst_cnt <= burst_cnt + 1'b1;
      else
        burst_cnt <= '0;
    end
  end

  assign FetchGrant = outs.fetch_grant;
  assign DataGrant  = outs.data_grant;
  assign DmaGrant   = outs.dma_grant;
  assign AddrSel    = outs.addr_sel;
  assign PipeStall  = outs.pipe_stall;
  assign DmaActive  = outs.dma_active;

endmodule

// File: tb/tb_pipeline_bus_arbiter.sv
// Directed-vector bench for pipeline_bus_arbiter (DMA_MAX_BURST=16, DMA_GAP=2).
module tb_pipeline_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       fetch_req, data_req, dma_req;
  logic       fetch_grant, data_grant, dma_grant;
  logic [1:0] addr_sel;
  logic       pipe_stall, dma_active;

  int total = 0;
  int bad   = 0;

  // Expected output words {fetch,data,dma grants, addr_sel, stall, active}
  localparam logic [6:0] O_FETCH = 7'b100_01_0_0;
  localparam logic [6:0] O_PARK  = 7'b000_00_0_0;
  localparam logic [6:0] O_DATA  = 7'b010_10_1_0;
  localparam logic [6:0] O_DMA   = 7'b001_11_1_1;
  localparam logic [6:0] O_TURN  = 7'b000_00_1_0;
  localparam logic [6:0] O_RESET = 7'b000_00_1_0;

  typedef struct {
    logic       f;
    logic       d;
    logic       m;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[$];

  pipeline_bus_arbiter #(
    .DMA_MAX_BURST(16),
    .DMA_GAP      (2)
  ) dut (
    .ClockIn   (clk),
    .ResetIn_n (rst_n),
    .FetchReq  (fetch_req),
    .DataReq   (data_req),
    .DmaReq    (dma_req),
    .FetchGrant(fetch_grant),
    .DataGrant (data_grant),
    .DmaGrant  (dma_grant),
    .AddrSel   (addr_sel),
    .PipeStall (pipe_stall),
    .DmaActive (dma_active)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] actual();
    return {fetch_grant, data_grant, dma_grant, addr_sel, pipe_stall, dma_active};
  endfunction

  task automatic check(input string name, input logic [6:0] exp);
    logic [6:0] act;
    act = actual();
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b required %b", name, act, exp);
    end
  endtask

  task automatic check_onehot(input string name);
    int n;
    n = $countones({fetch_grant, data_grant, dma_grant});
    total++;
    if (n > 1) begin
      bad++;
      $display("FAIL %s: %0d grants high, required at most 1", name, n);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic f, input logic d, input logic m);
    fetch_req = f;
    data_req  = d;
    dma_req   = m;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0);

    // release with fetch, fetch + 2-cycle data pulse, park, data from park
    vecs.push_back('{1'b1, 1'b0, 1'b0, O_FETCH});
    vecs.push_back('{1'b1, 1'b0, 1'b0, O_FETCH});
    vecs.push_back('{1'b1, 1'b1, 1'b0, O_DATA});
    vecs.push_back('{1'b1, 1'b1, 1'b0, O_DATA});
    vecs.push_back('{1'b1, 1'b0, 1'b0, O_FETCH});
    vecs.push_back('{1'b0, 1'b0, 1'b0, O_PARK});
    vecs.push_back('{1'b0, 1'b1, 1'b0, O_DATA});
    vecs.push_back('{1'b0, 1'b0, 1'b0, O_PARK});
    // all three at once: data, then dma, then fetch; gap masks re-grant
    vecs.push_back('{1'b1, 1'b1, 1'b1, O_DATA});
    vecs.push_back('{1'b1, 1'b1, 1'b1, O_DATA});
    vecs.push_back('{1'b1, 1'b0, 1'b1, O_DMA});
    vecs.push_back('{1'b1, 1'b0, 1'b1, O_DMA});
    vecs.push_back('{1'b1, 1'b0, 1'b0, O_TURN});
    vecs.push_back('{1'b1, 1'b0, 1'b1, O_FETCH});
    vecs.push_back('{1'b1, 1'b0, 1'b1, O_FETCH});
    vecs.push_back('{1'b1, 1'b0, 1'b1, O_DMA});
    vecs.push_back('{1'b1, 1'b0, 1'b0, O_TURN});
    // DMA dropped and re-raised inside the gap window
    vecs.push_back('{1'b0, 1'b0, 1'b0, O_PARK});
    vecs.push_back('{1'b0, 1'b0, 1'b1, O_PARK});
    vecs.push_back('{1'b0, 1'b0, 1'b1, O_DMA});
    vecs.push_back('{1'b0, 1'b0, 1'b0, O_TURN});
    vecs.push_back('{1'b0, 1'b0, 1'b0, O_PARK});
    vecs.push_back('{1'b0, 1'b0, 1'b0, O_PARK});
    vecs.push_back('{1'b0, 1'b0, 1'b0, O_PARK});
    vecs.push_back('{1'b0, 1'b0, 1'b0, O_PARK});

    repeat (3) step();
    check("reset_state", O_RESET);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].f, vecs[i].d, vecs[i].m);
      step();
      check($sformatf("vec%0d", i), vecs[i].exp);
      check_onehot($sformatf("vec%0d_onehot", i));
    end

    // DMA held 40 cycles: 16 burst, 1 turn, 2 fetch, repeat
    drive(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 40; i++) begin
      int p;
      step();
      p = i % 19;
      if (p < 16)       check($sformatf("burst_c%0d", i), O_DMA);
      else if (p == 16) check($sformatf("burst_c%0d", i), O_TURN);
      else              check($sformatf("burst_c%0d", i), O_FETCH);
      check_onehot($sformatf("burst_c%0d_onehot", i));
    end
    drive(1'b1, 1'b0, 1'b0);
    step(); check("burst_drop_turn", O_TURN);
    for (int i = 0; i < 3; i++) begin
      step(); check($sformatf("burst_drop_fetch%0d", i), O_FETCH);
    end

    // DataReq arrives at DMA cycle 5 and waits for the burst to release
    drive(1'b1, 1'b0, 1'b1);
    for (int k = 1; k <= 16; k++) begin
      step();
      check($sformatf("noprempt_dma%0d", k), O_DMA);
      if (k == 5) data_req = 1'b1;
    end
    step(); check("noprempt_turn", O_TURN);
    step(); check("noprempt_data1", O_DATA);
    step(); check("noprempt_data2", O_DATA);
    data_req = 1'b0;
    step(); check("after_data_dma", O_DMA);

    // reset asserted in DMA cycle 7; burst counter restarts afterwards
    for (int k = 2; k <= 7; k++) step();
    check("pre_reset_dma7", O_DMA);
    #2 rst_n = 1'b0;
    #1 check("async_reset", O_RESET);
    step(); step();
    check("held_reset", O_RESET);
    drive(1'b1, 1'b0, 1'b1);
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step(); check($sformatf("post_reset_dma%0d", k), O_DMA);
    end
    step(); check("post_reset_turn", O_TURN);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
